// File: rtl/field_pkg.sv
// Shared constants for the line-clear engine: field geometry, FSM encoding and score table.
package field_pkg;

  localparam int FIELD_W    = 20;
  localparam int FIELD_H    = 20;
  localparam int FIELD_BITS = FIELD_W * FIELD_H;
  localparam int CNT_W      = 5;
  localparam int ROW_W      = $clog2(FIELD_H);

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_SCAN  = 2'd1;
  localparam state_t ST_SHIFT = 2'd2;
  localparam state_t ST_DONE  = 2'd3;

  localparam logic [15:0] SCORE_1 = 16'd40;
  localparam logic [15:0] SCORE_2 = 16'd100;
  localparam logic [15:0] SCORE_3 = 16'd300;
  localparam logic [15:0] SCORE_4 = 16'd1200;

  // Adds the award for k cleared rows, saturating at 16'hFFFF.
  function automatic logic [15:0] score_add(input logic [15:0] cur, input logic [CNT_W-1:0] k);
    logic [15:0] inc;
    logic [16:0] sum;
    case (k)
      CNT_W'(0): inc = 16'd0;
      CNT_W'(1): inc = SCORE_1;
      CNT_W'(2): inc = SCORE_2;
      CNT_W'(3): inc = SCORE_3;
      default:   inc = SCORE_4;
    endcase
    sum = {1'b0, cur} + {1'b0, inc};
    return sum[16] ? 16'hFFFF : sum[15:0];
  endfunction

endpackage

// File: rtl/field_row_select.sv
// Combinational row picker: returns row r of the field and whether every cell in it is set.
module field_row_select
  import field_pkg::*;
(
  input  logic [FIELD_BITS-1:0] field,
  input  logic [ROW_W-1:0]      r,
  output logic [FIELD_W-1:0]    row_bits,
  output logic                  row_full
);

  always_comb begin
    // NOTE: default first so no path leaves row_bits unassigned (no latch).
    row_bits = '0;
    for (int y = 0; y < FIELD_H; y++) begin
      if (r == ROW_W'(y)) row_bits = field[y*FIELD_W +: FIELD_W];
    end
    row_full = &row_bits;
  end

endmodule

// File: rtl/field_line_clear.sv
// Row-serial line-clear engine: scans bottom-up, removes full rows, returns compacted field.
// Optional score output enabled by defining FIELD_LINE_CLEAR_SCORE_EN.
module field_line_clear
  import field_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [FIELD_BITS-1:0] field_in,
  output logic                  busy,
  output logic                  done,
  output logic [FIELD_BITS-1:0] field_out,
  output logic [CNT_W-1:0]      lines_cleared
`ifdef FIELD_LINE_CLEAR_SCORE_EN
  ,
  output logic [15:0]           score
`endif
);

  state_t                state_q, state_d;
  logic [FIELD_BITS-1:0] work_q, work_d;
  logic [ROW_W-1:0]      r_q, r_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [FIELD_BITS-1:0] field_out_q, field_out_d;
  logic [CNT_W-1:0]      lines_q, lines_d;
  logic [FIELD_W-1:0]    row_bits;
  logic                  row_full;
  logic                  finish;

  field_row_select u_row_select (
    .field    (work_q),
    .r        (r_q),
    .row_bits (row_bits),
    .row_full (row_full)
  );

  assign finish = (state_q == ST_SCAN) && !row_full && (r_q == '0);

  always_ff @(posedge clk) begin
    // NOTE: synchronous reset; every register, work field included, clears so an abort leaves no stale data.
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start) state_d = ST_SCAN;
      ST_SCAN:  if (row_full) state_d = ST_SHIFT;
                else if (r_q == '0) state_d = ST_DONE;
      ST_SHIFT: state_d = ST_SCAN;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == ST_SCAN) || (state_q == ST_SHIFT);
    done = (state_q == ST_DONE);
  end

  always_comb begin
    work_d      = work_q;
    r_d         = r_q;
    count_d     = count_q;
    field_out_d = field_out_q;
    lines_d     = lines_q;
    if (state_q == ST_IDLE && start) begin
      work_d  = field_in;
      r_d     = ROW_W'(FIELD_H - 1);
      count_d = '0;
    end
    if (state_q == ST_SCAN && !row_full && r_q != '0) r_d = r_q - ROW_W'(1);
    if (state_q == ST_SHIFT) begin
      // Rows at or above r drop by one; row 0 always refills with zeros.
      work_d[0 +: FIELD_W] = '0;
      for (int y = 1; y < FIELD_H; y++) begin
        if (ROW_W'(y) <= r_q) work_d[y*FIELD_W +: FIELD_W] = work_q[(y-1)*FIELD_W +: FIELD_W];
      end
      count_d = count_q + CNT_W'(1);
    end
    if (finish) begin
      field_out_d = work_q;
      lines_d     = count_q;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments for all state so every flop samples pre-edge values.
    if (rst) begin
      work_q      <= '0;
      r_q         <= ROW_W'(FIELD_H - 1);
      count_q     <= '0;
      field_out_q <= '0;
      lines_q     <= '0;
    end else begin
      work_q      <= work_d;
      r_q         <= r_d;
      count_q     <= count_d;
      field_out_q <= field_out_d;
      lines_q     <= lines_d;
    end
  end

  assign field_out     = field_out_q;
  assign lines_cleared = lines_q;

`ifdef FIELD_LINE_CLEAR_SCORE_EN
  logic [15:0] score_q, score_d;

  always_comb begin
    score_d = score_q;
    if (finish) score_d = score_add(score_q, count_q);
  end

  always_ff @(posedge clk) begin
    if (rst) score_q <= '0;
    else     score_q <= score_d;
  end

  assign score = score_q;
`endif

endmodule

// File: tb/tb_field_line_clear.sv
// Scoreboard bench for field_line_clear: stimulus pushes expectations, a monitor checks each done.
module tb_field_line_clear;
  import field_pkg::*;

  typedef struct {
    logic [FIELD_BITS-1:0] field;
    logic [CNT_W-1:0]      lines;
    int                    accept;
    int                    lat;
`ifdef FIELD_LINE_CLEAR_SCORE_EN
    logic [15:0]           score;
`endif
  } exp_t;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  start = 1'b0;
  logic [FIELD_BITS-1:0] field_in = '0;
  logic                  busy, done;
  logic [FIELD_BITS-1:0] field_out;
  logic [CNT_W-1:0]      lines_cleared;
`ifdef FIELD_LINE_CLEAR_SCORE_EN
  logic [15:0]           score;
`endif

  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  exp_t sb[$];
  logic [15:0] score_model = 16'd0;

  field_line_clear dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .field_in      (field_in),
    .busy          (busy),
    .done          (done),
    .field_out     (field_out),
    .lines_cleared (lines_cleared)
`ifdef FIELD_LINE_CLEAR_SCORE_EN
    ,
    .score         (score)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [FIELD_BITS-1:0] act, input logic [FIELD_BITS-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [FIELD_BITS-1:0] row_val(input int y, input logic [FIELD_W-1:0] bits);
    logic [FIELD_BITS-1:0] f;
    f = '0;
    f[y*FIELD_W +: FIELD_W] = bits;
    return f;
  endfunction

  function automatic logic [15:0] award(input int k);
    case (k)
      0: return 16'd0;
      1: return 16'd40;
      2: return 16'd100;
      3: return 16'd300;
      default: return 16'd1200;
    endcase
  endfunction

  // Expected entry for a run accepted at the given edge.
  task automatic push_exp(input logic [FIELD_BITS-1:0] f, input int k, input int accept);
    exp_t e;
    e.field  = f;
    e.lines  = CNT_W'(k);
    e.accept = accept;
    e.lat    = FIELD_H + 2*k;
`ifdef FIELD_LINE_CLEAR_SCORE_EN
    score_model = score_model + award(k);
    e.score     = score_model;
`endif
    sb.push_back(e);
  endtask

  // Monitor: every done pulse is matched to the oldest expectation.
  always @(negedge clk) begin
    if (!rst && done) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("field_out", field_out, e.field);
        check("lines_cleared", FIELD_BITS'(lines_cleared), FIELD_BITS'(e.lines));
        check("latency", FIELD_BITS'(cyc - e.accept), FIELD_BITS'(e.lat));
        check("busy_in_done", FIELD_BITS'(busy), '0);
`ifdef FIELD_LINE_CLEAR_SCORE_EN
        check("score", FIELD_BITS'(score), FIELD_BITS'(e.score));
`endif
      end
    end
  end

  task automatic wait_done(input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (!done && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!done) check({name, "_timeout"}, 1, 0);
  endtask

  task automatic run(input logic [FIELD_BITS-1:0] f, input logic [FIELD_BITS-1:0] exp_f, input int k, input string name);
    field_in = f;
    start    = 1'b1;
    push_exp(exp_f, k, cyc + 1);
    @(negedge clk);
    start = 1'b0;
    wait_done(name);
  endtask

  logic [FIELD_BITS-1:0] all_ones;
  logic [FIELD_BITS-1:0] f2, e2, f3, e3;

  initial begin
    all_ones = '1;
    f2 = row_val(19, '1);
    f2[18*FIELD_W + 3] = 1'b1;
    e2 = '0;
    e2[19*FIELD_W + 3] = 1'b1;
    f3 = row_val(19, '1) | row_val(17, '1) | row_val(18, 20'h00001);
    e3 = row_val(19, 20'h00001);

    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_busy", FIELD_BITS'(busy), '0);
    check("rst_done", FIELD_BITS'(done), '0);
    check("rst_field_out", field_out, '0);
    check("rst_lines", FIELD_BITS'(lines_cleared), '0);
`ifdef FIELD_LINE_CLEAR_SCORE_EN
    check("rst_score", FIELD_BITS'(score), '0);
`endif

    // Empty field, with busy watched edge by edge.
    field_in = '0;
    start    = 1'b1;
    push_exp('0, 0, cyc + 1);
    @(negedge clk);
    start = 1'b0;
    for (int i = 1; i <= 19; i++) begin
      @(negedge clk);
      check("empty_busy", FIELD_BITS'({busy, done}), FIELD_BITS'(2'b10));
    end
    @(negedge clk);
    check("empty_done_edge20", FIELD_BITS'({busy, done}), FIELD_BITS'(2'b01));
    @(negedge clk);
    check("done_one_cycle", FIELD_BITS'(done), '0);

    run(f2, e2, 1, "one_row");
    check("hold_after_done", field_out, e2);
    @(negedge clk);
    run(f3, e3, 2, "two_rows");
    @(negedge clk);
    run(all_ones, '0, 20, "all_ones_a");
    @(negedge clk);
    run(all_ones, '0, 20, "all_ones_b");
    @(negedge clk);

    // start held high; field_in changes mid-run and only takes effect on the back-to-back run.
    field_in = row_val(19, '1);
    start    = 1'b1;
    push_exp('0, 1, cyc + 1);
    repeat (4) @(negedge clk);
    field_in = f3;
    wait_done("held_first");
    push_exp(e3, 2, cyc + 2);
    repeat (2) @(negedge clk);
    start = 1'b0;
    wait_done("held_second");
    @(negedge clk);

    // Reset while in SHIFT: edge 1 after accept enters SHIFT for an all-ones field.
    field_in = all_ones;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    score_model = 16'd0;
    check("abort_busy", FIELD_BITS'(busy), '0);
    check("abort_done", FIELD_BITS'(done), '0);
    check("abort_field_out", field_out, '0);
    check("abort_lines", FIELD_BITS'(lines_cleared), '0);
    run(f2, e2, 1, "after_abort");

    repeat (3) @(negedge clk);
    check("scoreboard_drained", FIELD_BITS'(sb.size()), '0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
